// File: rtl/mult_arbiter_rr.sv
// Round-robin arbiter that time-shares one external combinational 8x8 multiplier
// between requesters A and B, returning each tagged product over valid/ready.
module mult_arbiter_rr #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_a,
  input  logic [WIDTH-1:0]   x_a,
  input  logic [WIDTH-1:0]   y_a,
  output logic               gnt_a,
  input  logic               req_b,
  input  logic [WIDTH-1:0]   x_b,
  input  logic [WIDTH-1:0]   y_b,
  output logic               gnt_b,
  output logic [WIDTH-1:0]   mul_x,
  output logic [WIDTH-1:0]   mul_y,
  input  logic [2*WIDTH-1:0] mul_z,
  output logic [2*WIDTH-1:0] z_out,
  output logic               z_id,
  output logic               z_valid,
  input  logic               z_ready,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mul_x_q, mul_x_d;
  logic [WIDTH-1:0]   mul_y_q, mul_y_d;
  logic [2*WIDTH-1:0] z_out_q, z_out_d;
  logic               z_id_q, z_id_d;
  logic               z_valid_q, z_valid_d;
  logic               gnt_a_q, gnt_a_d;
  logic               gnt_b_q, gnt_b_d;
  logic               last_id_q, last_id_d;
  logic               sel_b;

  // B wins if it is the only requester, or on a tie when A was served last.
  assign sel_b = req_b & (~req_a | ~last_id_q);

  always_comb begin
    // NOTE: every _d gets a hold/default value first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    mul_x_d   = mul_x_q;
    mul_y_d   = mul_y_q;
    z_out_d   = z_out_q;
    z_id_d    = z_id_q;
    z_valid_d = z_valid_q;
    last_id_d = last_id_q;
    gnt_a_d   = 1'b0;
    gnt_b_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_a | req_b) begin
          mul_x_d = sel_b ? x_b : x_a;
          mul_y_d = sel_b ? y_b : y_a;
          z_id_d  = sel_b;
          gnt_a_d = ~sel_b;
          gnt_b_d = sel_b;
          state_d = MUL;
        end
      end
      MUL: begin
        // Operands have been stable on mul_x/mul_y for a full cycle.
        z_out_d   = mul_z;
        z_valid_d = 1'b1;
        state_d   = DONE;
      end
      DONE: begin
        if (z_ready) begin
          z_valid_d = 1'b0;
          last_id_d = z_id_q;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      mul_x_q   <= '0;
      mul_y_q   <= '0;
      z_out_q   <= '0;
      z_id_q    <= 1'b0;
      z_valid_q <= 1'b0;
      gnt_a_q   <= 1'b0;
      gnt_b_q   <= 1'b0;
      last_id_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      mul_x_q   <= mul_x_d;
      mul_y_q   <= mul_y_d;
      z_out_q   <= z_out_d;
      z_id_q    <= z_id_d;
      z_valid_q <= z_valid_d;
      gnt_a_q   <= gnt_a_d;
      gnt_b_q   <= gnt_b_d;
      last_id_q <= last_id_d;
    end
  end

  assign gnt_a   = gnt_a_q;
  assign gnt_b   = gnt_b_q;
  assign mul_x   = mul_x_q;
  assign mul_y   = mul_y_q;
  assign z_out   = z_out_q;
  assign z_id    = z_id_q;
  assign z_valid = z_valid_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_mult_arbiter_rr.sv
// Directed plus randomized bench for mult_arbiter_rr; a transaction-level model
// predicts grants, results and timing from the arbitration and latency rules.
module tb_mult_arbiter_rr;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           req_a, req_b, z_ready;
  logic [W-1:0]   x_a, y_a, x_b, y_b;
  logic           gnt_a, gnt_b, z_id, z_valid, busy;
  logic [W-1:0]   mul_x, mul_y;
  logic [2*W-1:0] mul_z, z_out;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: busy flag, edges since the grant sample (1 = grant cycle, 2 = result waiting).
  bit             m_busy, m_id, m_last;
  int             m_age;
  logic [W-1:0]   m_x, m_y;
  logic [2*W-1:0] m_z, m_zout;
  bit             auto_a, auto_b;

  mult_arbiter_rr #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .x_a(x_a), .y_a(y_a), .gnt_a(gnt_a),
    .req_b(req_b), .x_b(x_b), .y_b(y_b), .gnt_b(gnt_b),
    .mul_x(mul_x), .mul_y(mul_y), .mul_z(mul_z),
    .z_out(z_out), .z_id(z_id), .z_valid(z_valid), .z_ready(z_ready),
    .busy(busy)
  );

  // Stand-in for the external combinational multiply_8_bit.
  assign mul_z = 16'(mul_x) * 16'(mul_y);

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_age = 0; m_id = 1'b0; m_last = 1'b1;
    m_x = '0; m_y = '0; m_z = '0; m_zout = '0;
  endtask

  // Applies the rules for the upcoming rising edge using the inputs now driven.
  task automatic model_edge();
    bit pick_b;
    if (!m_busy) begin
      if (req_a || req_b) begin
        pick_b = (req_a && req_b) ? !m_last : req_b;
        m_id   = pick_b;
        m_x    = pick_b ? x_b : x_a;
        m_y    = pick_b ? y_b : y_a;
        m_z    = 16'(int'(m_x) * int'(m_y));
        m_busy = 1'b1;
        m_age  = 1;
      end
    end else if (m_age == 1) begin
      m_age  = 2;
      m_zout = m_z;
    end else if (z_ready) begin
      m_busy = 1'b0;
      m_last = m_id;
    end
  endtask

  task automatic check_outputs();
    bit g;
    g = m_busy && (m_age == 1);
    check("gnt_a",   32'(gnt_a),   32'(g && !m_id));
    check("gnt_b",   32'(gnt_b),   32'(g && m_id));
    check("z_valid", 32'(z_valid), 32'(m_busy && m_age == 2));
    check("busy",    32'(busy),    32'(m_busy));
    check("mul_x",   32'(mul_x),   32'(m_x));
    check("mul_y",   32'(mul_y),   32'(m_y));
    check("z_out",   32'(z_out),   32'(m_zout));
    check("z_id",    32'(z_id),    32'(m_id));
  endtask

  // Requesters drop req in their grant cycle; auto mode re-raises on the next cycle.
  task automatic react();
    bit g;
    g = m_busy && (m_age == 1);
    if (g && !m_id) req_a = 1'b0;
    else if (auto_a && !req_a) begin
      req_a = 1'b1; x_a = 8'($urandom); y_a = 8'($urandom);
    end
    if (g && m_id) req_b = 1'b0;
    else if (auto_b && !req_b) begin
      req_b = 1'b1; x_b = 8'($urandom); y_b = 8'($urandom);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_outputs();
    react();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #1;
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req_a = 1'b0; req_b = 1'b0; z_ready = 1'b1;
    x_a = '0; y_a = '0; x_b = '0; y_b = '0;
    auto_a = 1'b0; auto_b = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    reset = 1'b0;

    // Single A request: 10 * 2
    req_a = 1'b1; x_a = 8'd10; y_a = 8'd2;
    step();
    check("t1_gnt_a", 32'(gnt_a), 32'd1);
    step();
    check("t1_z_valid", 32'(z_valid), 32'd1);
    check("t1_z_out", 32'(z_out), 32'd20);
    step();
    check("t1_busy_low", 32'(busy), 32'd0);
    repeat (2) step();

    // Simultaneous requests straight out of reset: A wins the first tie.
    do_reset();
    req_a = 1'b1; x_a = 8'd20; y_a = 8'd4;
    req_b = 1'b1; x_b = 8'd20; y_b = 8'd5;
    step();
    check("t2_first_gnt_a", 32'(gnt_a), 32'd1);
    step();
    check("t2_first_z", 32'(z_out), 32'd80);
    repeat (2) step();
    check("t2_second_gnt_b", 32'(gnt_b), 32'd1);
    step();
    check("t2_second_z", 32'(z_out), 32'd100);
    check("t2_second_id", 32'(z_id), 32'd1);
    repeat (3) step();

    // Continuous contention: grants must alternate.
    auto_a = 1'b1; auto_b = 1'b1;
    repeat (24) step();
    auto_a = 1'b0; auto_b = 1'b0;
    repeat (12) step();

    // Back-pressure on B(255,255) while A waits.
    z_ready = 1'b0;
    req_b = 1'b1; x_b = 8'd255; y_b = 8'd255;
    repeat (2) step();
    req_a = 1'b1; x_a = 8'($urandom); y_a = 8'($urandom);
    repeat (5) step();
    check("t4_stall_z", 32'(z_out), 32'd65025);
    check("t4_stall_valid", 32'(z_valid), 32'd1);
    z_ready = 1'b1;
    repeat (6) step();

    // Reset in the MUL cycle of A(7,9); A keeps requesting and is re-granted.
    req_a = 1'b1; x_a = 8'd7; y_a = 8'd9;
    step();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_outputs();
    req_a = 1'b1;
    @(posedge clk);
    #1;
    check_outputs();
    reset = 1'b0;
    repeat (2) step();
    check("t5_regrant_z", 32'(z_out), 32'd63);
    repeat (3) step();

    // Late B request while A's result is held in DONE.
    z_ready = 1'b0;
    req_a = 1'b1; x_a = 8'($urandom); y_a = 8'($urandom);
    repeat (2) step();
    req_b = 1'b1; x_b = 8'($urandom); y_b = 8'($urandom);
    repeat (2) step();
    z_ready = 1'b1;
    repeat (6) step();

    // Randomized traffic with random back-pressure.
    auto_a = 1'b1; auto_b = 1'b1;
    repeat (150) begin
      z_ready = 1'($urandom_range(0, 1));
      step();
    end
    auto_a = 1'b0; auto_b = 1'b0;
    z_ready = 1'b1;
    repeat (12) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
